// File: rtl/cache_write_buffer_pkg.sv
// -----------------------------------------------------------------------------
// cache_write_buffer_pkg
// Shared definitions for the cache write buffer:
//   - default cache geometry (CACHE_T / CACHE_S / CACHE_B bits of a 32-bit
//     address), which the top uses as parameter defaults
//   - write-buffer state width and encodings (IDLE=0, FILL=1, DRAIN=2)
// -----------------------------------------------------------------------------
package cache_write_buffer_pkg;

  localparam int unsigned CACHE_T = 23;  // tag bits
  localparam int unsigned CACHE_S = 4;   // set index bits
  localparam int unsigned CACHE_B = 5;   // byte-offset bits (8-word lines)

  localparam int unsigned WB_STATE_WIDTH = 2;

  typedef enum logic [WB_STATE_WIDTH-1:0] {
    WB_IDLE  = 2'd0,
    WB_FILL  = 2'd1,
    WB_DRAIN = 2'd2
  } wb_state_e;

endpackage

// File: rtl/wb_line_buffer.sv
// -----------------------------------------------------------------------------
// wb_line_buffer
// Storage for one cache line held by the write buffer.
// Ports:
//   clk_i, rst_ni        clock / asynchronous active-low reset (valid bits only)
//   clr_i                clear every valid bit (line fully drained)
//   we_i, waddr_i,       single write port: word offset and data
//   wdata_i
//   drain_addr_i/_data_o combinational read port used by the memory drain
//   fwd_addr_i/_data_o,  combinational read port used for refill forwarding,
//   fwd_valid_o          with the valid bit of the addressed word
// -----------------------------------------------------------------------------
module wb_line_buffer
  import cache_write_buffer_pkg::*;
#(
  parameter int unsigned OFFSET_WIDTH = CACHE_B
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clr_i,
  input  logic                    we_i,
  input  logic [OFFSET_WIDTH-3:0] waddr_i,
  input  logic [31:0]             wdata_i,
  input  logic [OFFSET_WIDTH-3:0] drain_addr_i,
  output logic [31:0]             drain_data_o,
  input  logic [OFFSET_WIDTH-3:0] fwd_addr_i,
  output logic [31:0]             fwd_data_o,
  output logic                    fwd_valid_o
);

  localparam int unsigned OFF_W     = OFFSET_WIDTH - 2;
  localparam int unsigned LINE_SIZE = 2 ** OFF_W;

  // Data words carry no reset: a word is only ever observed after it has
  // been written, and the valid bits below qualify the forward path.
  logic [31:0]          data_q [LINE_SIZE];
  logic [LINE_SIZE-1:0] valid;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      data_q[waddr_i] <= wdata_i;
    end
  end

  for (genvar gi = 0; gi < LINE_SIZE; gi++) begin : g_valid
    logic valid_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        valid_q <= 1'b0;
      end else if (clr_i) begin
        valid_q <= 1'b0;
      end else if (we_i && (waddr_i == OFF_W'(gi))) begin
        valid_q <= 1'b1;
      end
    end
    assign valid[gi] = valid_q;
  end

  assign drain_data_o = data_q[drain_addr_i];
  assign fwd_data_o   = data_q[fwd_addr_i];
  assign fwd_valid_o  = valid[fwd_addr_i];

endmodule

// File: rtl/cache_write_buffer.sv
// -----------------------------------------------------------------------------
// cache_write_buffer
// Captures an evicted dirty line word-by-word from the cache controller and
// drains it to main memory over a valid/ready handshake.
// Optional feature macro: CACHE_WB_FORWARD_EN -- when defined, buffered words
// are forwarded to refills of the same line; when undefined rd_hit_o/rd_data_o
// are tied to 0.
// Ports:
//   clk_i, rst_ni          clock / asynchronous active-low reset
//   wb_en_i, wb_addr_i,    capture strobe, word address and data
//   wb_data_i
//   rd_addr_i              refill address for forwarding
//   rd_hit_o, rd_data_o    forwarding hit and word (combinational)
//   full_o                 buffer busy (FILL or DRAIN)
//   overflow_o             capture dropped this cycle (combinational pulse)
//   mem_req_o, mem_addr_o, memory write request, address, data
//   mem_wdata_o
//   mem_ready_i            memory accepts the request this cycle
// -----------------------------------------------------------------------------
module cache_write_buffer
  import cache_write_buffer_pkg::*;
#(
  parameter int unsigned TAG_WIDTH    = CACHE_T,
  parameter int unsigned SET_WIDTH    = CACHE_S,
  parameter int unsigned OFFSET_WIDTH = CACHE_B
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        wb_en_i,
  input  logic [31:0] wb_addr_i,
  input  logic [31:0] wb_data_i,
  input  logic [31:0] rd_addr_i,
  output logic        rd_hit_o,
  output logic [31:0] rd_data_o,
  output logic        full_o,
  output logic        overflow_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ready_i
);

  localparam int unsigned LINE_W    = TAG_WIDTH + SET_WIDTH;
  localparam int unsigned OFF_W     = OFFSET_WIDTH - 2;
  localparam int unsigned CNT_W     = OFFSET_WIDTH - 1;
  localparam int unsigned LINE_SIZE = 2 ** OFF_W;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LINE_SIZE - 1);

  wb_state_e         state_q, state_d;
  logic [CNT_W-1:0]  fill_cnt_q, fill_cnt_d;
  logic [CNT_W-1:0]  drain_cnt_q, drain_cnt_d;
  logic [LINE_W-1:0] line_q, line_d;

  logic              buf_we;
  logic              buf_clr;
  logic [31:0]       drain_data;
  logic [31:0]       fwd_data;
  logic              fwd_valid;

  logic [LINE_W-1:0] wb_line;
  logic [OFF_W-1:0]  wb_off;
  assign wb_line = wb_addr_i[31:OFFSET_WIDTH];
  assign wb_off  = wb_addr_i[OFFSET_WIDTH-1:2];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= WB_IDLE;
      fill_cnt_q  <= '0;
      drain_cnt_q <= '0;
      line_q      <= '0;
    end else begin
      state_q     <= state_d;
      fill_cnt_q  <= fill_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      line_q      <= line_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    fill_cnt_d  = fill_cnt_q;
    drain_cnt_d = drain_cnt_q;
    line_d      = line_q;
    buf_we      = 1'b0;
    buf_clr     = 1'b0;
    overflow_o  = 1'b0;
    unique case (state_q)
      WB_IDLE: begin
        if (wb_en_i) begin
          line_d     = wb_line;
          buf_we     = 1'b1;
          fill_cnt_d = CNT_W'(1);
          state_d    = WB_FILL;
        end
      end
      WB_FILL: begin
        if (wb_en_i) begin
          if (wb_line != line_q) begin
            // A word from another line cannot share the buffer; drop it.
            overflow_o = 1'b1;
          end else begin
            buf_we     = 1'b1;
            fill_cnt_d = fill_cnt_q + CNT_W'(1);
            // This write brings the count to LINE_SIZE.
            if (fill_cnt_q == LAST_IDX) begin
              state_d     = WB_DRAIN;
              drain_cnt_d = '0;
            end
          end
        end
      end
      WB_DRAIN: begin
        overflow_o = wb_en_i;
        if (mem_ready_i) begin
          if (drain_cnt_q == LAST_IDX) begin
            state_d     = WB_IDLE;
            buf_clr     = 1'b1;
            fill_cnt_d  = '0;
            drain_cnt_d = '0;
          end else begin
            drain_cnt_d = drain_cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = WB_IDLE;
    endcase
  end

  wb_line_buffer #(
    .OFFSET_WIDTH(OFFSET_WIDTH)
  ) u_line_buffer (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clr_i       (buf_clr),
    .we_i        (buf_we),
    .waddr_i     (wb_off),
    .wdata_i     (wb_data_i),
    .drain_addr_i(drain_cnt_q[OFF_W-1:0]),
    .drain_data_o(drain_data),
    .fwd_addr_i  (rd_addr_i[OFFSET_WIDTH-1:2]),
    .fwd_data_o  (fwd_data),
    .fwd_valid_o (fwd_valid)
  );

  // Address/data are gated so the memory bus reads 0 outside DRAIN.
  assign full_o      = (state_q != WB_IDLE);
  assign mem_req_o   = (state_q == WB_DRAIN);
  assign mem_addr_o  = mem_req_o ? {line_q, drain_cnt_q[OFF_W-1:0], 2'b00} : '0;
  assign mem_wdata_o = mem_req_o ? drain_data : '0;

  logic unused_bits;
`ifdef CACHE_WB_FORWARD_EN
  assign rd_hit_o    = (state_q != WB_IDLE) && (rd_addr_i[31:OFFSET_WIDTH] == line_q)
                       && fwd_valid;
  assign rd_data_o   = rd_hit_o ? fwd_data : '0;
  assign unused_bits = ^{wb_addr_i[1:0], rd_addr_i[1:0]};
`else
  assign rd_hit_o    = 1'b0;
  assign rd_data_o   = '0;
  assign unused_bits = ^{wb_addr_i[1:0], rd_addr_i, fwd_data, fwd_valid};
`endif

endmodule

// File: tb/tb_cache_write_buffer.sv
module tb_cache_write_buffer;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        wb_en_i;
  logic [31:0] wb_addr_i;
  logic [31:0] wb_data_i;
  logic [31:0] rd_addr_i;
  logic        rd_hit_o;
  logic [31:0] rd_data_o;
  logic        full_o;
  logic        overflow_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ready_i;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  cache_write_buffer dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .wb_en_i    (wb_en_i),
    .wb_addr_i  (wb_addr_i),
    .wb_data_i  (wb_data_i),
    .rd_addr_i  (rd_addr_i),
    .rd_hit_o   (rd_hit_o),
    .rd_data_o  (rd_data_o),
    .full_o     (full_o),
    .overflow_o (overflow_o),
    .mem_req_o  (mem_req_o),
    .mem_addr_o (mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_ready_i(mem_ready_i)
  );

  // Stimulus helpers (no checking). Each returns 1 time unit after a posedge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic put_word(input logic [31:0] a, input logic [31:0] d);
    wb_en_i   = 1'b1;
    wb_addr_i = a;
    wb_data_i = d;
    step();
    wb_en_i   = 1'b0;
  endtask

  task automatic fill_line(input logic [31:0] base, input logic [31:0] dbase);
    for (int i = 0; i < 8; i++) put_word(base + 32'(4 * i), dbase + 32'(i));
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    #2;
    checks++;
    if ({mem_req_o, full_o, overflow_o, rd_hit_o} !== 4'b0 || mem_addr_o !== 32'h0 ||
        mem_wdata_o !== 32'h0 || rd_data_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: req=%b full=%b ovf=%b hit=%b addr=%h wdata=%h rdata=%h, want all 0",
               mem_req_o, full_o, overflow_o, rd_hit_o, mem_addr_o, mem_wdata_o, rd_data_o);
    end
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (3) step();
    checks++;
    if (full_o !== 1'b0 || mem_req_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: full=%b req=%b, want 0 0", full_o, mem_req_o);
    end
    // Assert reset mid-cycle during FILL: outputs must clear without a clock.
    put_word(32'h1000_0040, 32'h11);
    checks++;
    if (full_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_fill_full: full=%b, want 1", full_o);
    end
    #2;
    rst_ni = 1'b0;
    #1;
    checks++;
    if (full_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: full=%b, want 0", full_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    step();
    $display("test_reset done");
  endtask

  task automatic test_fill_drain();
    mem_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      put_word(32'h1000_0040 + 32'(4 * i), 32'hA0 + 32'(i));
      if (i < 7) begin
        checks++;
        if (mem_req_o !== 1'b0 || full_o !== 1'b1) begin
          errors++;
          $display("FAIL fill_state[%0d]: req=%b full=%b, want 0 1", i, mem_req_o, full_o);
        end
      end
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h1000_0040 + 32'(4 * k) ||
          mem_wdata_o !== 32'hA0 + 32'(k)) begin
        errors++;
        $display("FAIL drain_word[%0d]: req=%b addr=%h data=%h, want 1 %h %h", k, mem_req_o,
                 mem_addr_o, mem_wdata_o, 32'h1000_0040 + 32'(4 * k), 32'hA0 + 32'(k));
      end
      step();
    end
    checks++;
    if (full_o !== 1'b0 || mem_req_o !== 1'b0) begin
      errors++;
      $display("FAIL drain_done: full=%b req=%b, want 0 0", full_o, mem_req_o);
    end
    $display("test_fill_drain done");
  endtask

  task automatic test_backpressure();
    int c = 0;
    int k = 0;
    fill_line(32'h1000_0040, 32'hA0);
    while (full_o === 1'b1 && c < 100) begin
      mem_ready_i = ((c % 3) == 2);
      checks++;
      if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h1000_0040 + 32'(4 * k) ||
          mem_wdata_o !== 32'hA0 + 32'(k)) begin
        errors++;
        $display("FAIL bp_word c=%0d k=%0d: req=%b addr=%h data=%h, want 1 %h %h", c, k,
                 mem_req_o, mem_addr_o, mem_wdata_o, 32'h1000_0040 + 32'(4 * k), 32'hA0 + 32'(k));
      end
      if (mem_ready_i) k++;
      step();
      c++;
    end
    mem_ready_i = 1'b1;
    checks++;
    if (c != 24 || k != 8) begin
      errors++;
      $display("FAIL bp_cycles: cycles=%0d words=%0d, want 24 8", c, k);
    end
    $display("test_backpressure done (%0d cycles)", c);
  endtask

  task automatic test_fill_gaps();
    int pat[5] = '{1, 0, 1, 1, 0};
    int n = 0;
    int p = 0;
    mem_ready_i = 1'b1;
    while (n < 8 && p < 40) begin
      if (pat[p % 5] == 1) begin
        put_word(32'h2000_0080 + 32'(4 * n), 32'hB0 + 32'(n));
        n++;
      end else begin
        step();
      end
      p++;
      if (n < 8) begin
        checks++;
        if (mem_req_o !== 1'b0 || full_o !== 1'b1) begin
          errors++;
          $display("FAIL gap_state p=%0d n=%0d: req=%b full=%b, want 0 1", p, n, mem_req_o, full_o);
        end
      end
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h2000_0080 + 32'(4 * k) ||
          mem_wdata_o !== 32'hB0 + 32'(k)) begin
        errors++;
        $display("FAIL gap_drain[%0d]: req=%b addr=%h data=%h, want 1 %h %h", k, mem_req_o,
                 mem_addr_o, mem_wdata_o, 32'h2000_0080 + 32'(4 * k), 32'hB0 + 32'(k));
      end
      step();
    end
    checks++;
    if (full_o !== 1'b0) begin
      errors++;
      $display("FAIL gap_done: full=%b, want 0", full_o);
    end
    $display("test_fill_gaps done");
  endtask

  task automatic test_overflow();
    mem_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) put_word(32'h1000_0040 + 32'(4 * i), 32'hA0 + 32'(i));
    // Different line, offset 3, during FILL.
    wb_en_i   = 1'b1;
    wb_addr_i = 32'h3000_004C;
    wb_data_i = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (overflow_o !== 1'b1) begin
      errors++;
      $display("FAIL ovf_fill: overflow=%b, want 1", overflow_o);
    end
    step();
    wb_en_i = 1'b0;
    #1;
    checks++;
    if (overflow_o !== 1'b0 || mem_req_o !== 1'b0) begin
      errors++;
      $display("FAIL ovf_fill_pulse: overflow=%b req=%b, want 0 0", overflow_o, mem_req_o);
    end
    for (int i = 3; i < 8; i++) begin
      put_word(32'h1000_0040 + 32'(4 * i), 32'hA0 + 32'(i));
      if (i < 7) begin
        checks++;
        if (mem_req_o !== 1'b0) begin
          errors++;
          $display("FAIL ovf_early_drain[%0d]: req=%b, want 0", i, mem_req_o);
        end
      end
    end
    // Same-line write during DRAIN is also dropped.
    wb_en_i   = 1'b1;
    wb_addr_i = 32'h1000_0040;
    wb_data_i = 32'h0000_0BAD;
    #1;
    checks++;
    if (overflow_o !== 1'b1 || mem_req_o !== 1'b1) begin
      errors++;
      $display("FAIL ovf_drain: overflow=%b req=%b, want 1 1", overflow_o, mem_req_o);
    end
    step();
    wb_en_i = 1'b0;
    #1;
    checks++;
    if (overflow_o !== 1'b0) begin
      errors++;
      $display("FAIL ovf_drain_pulse: overflow=%b, want 0", overflow_o);
    end
    mem_ready_i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (mem_addr_o !== 32'h1000_0040 + 32'(4 * k) || mem_wdata_o !== 32'hA0 + 32'(k)) begin
        errors++;
        $display("FAIL ovf_data[%0d]: addr=%h data=%h, want %h %h", k, mem_addr_o, mem_wdata_o,
                 32'h1000_0040 + 32'(4 * k), 32'hA0 + 32'(k));
      end
      step();
    end
    $display("test_overflow done");
  endtask

  task automatic test_forward();
    mem_ready_i = 1'b0;
    for (int i = 0; i < 2; i++) put_word(32'h1000_0040 + 32'(4 * i), 32'hA0 + 32'(i));
    rd_addr_i = 32'h1000_0048;
    #1;
    checks++;
    if (rd_hit_o !== 1'b0) begin
      errors++;
      $display("FAIL fwd_unwritten: hit=%b, want 0", rd_hit_o);
    end
    for (int i = 2; i < 8; i++) put_word(32'h1000_0040 + 32'(4 * i), 32'hA0 + 32'(i));
`ifdef CACHE_WB_FORWARD_EN
    checks++;
    if (rd_hit_o !== 1'b1 || rd_data_o !== 32'hA2) begin
      errors++;
      $display("FAIL fwd_hit: hit=%b data=%h, want 1 000000a2", rd_hit_o, rd_data_o);
    end
    rd_addr_i = 32'h1000_0068;
    #1;
    checks++;
    if (rd_hit_o !== 1'b0) begin
      errors++;
      $display("FAIL fwd_other_line: hit=%b, want 0", rd_hit_o);
    end
`else
    checks++;
    if (rd_hit_o !== 1'b0 || rd_data_o !== 32'h0) begin
      errors++;
      $display("FAIL fwd_disabled: hit=%b data=%h, want 0 0", rd_hit_o, rd_data_o);
    end
`endif
    mem_ready_i = 1'b1;
    repeat (8) step();
    rd_addr_i = 32'h1000_0048;
    #1;
    checks++;
    if (rd_hit_o !== 1'b0 || full_o !== 1'b0) begin
      errors++;
      $display("FAIL fwd_after_drain: hit=%b full=%b, want 0 0", rd_hit_o, full_o);
    end
    rd_addr_i = 32'h0;
    $display("test_forward done");
  endtask

  task automatic test_reset_mid_drain();
    mem_ready_i = 1'b0;
    fill_line(32'h1000_0040, 32'hA0);
    step();
    #2;
    rst_ni = 1'b0;
    #1;
    checks++;
    if (mem_req_o !== 1'b0 || full_o !== 1'b0 || mem_addr_o !== 32'h0) begin
      errors++;
      $display("FAIL rst_drain_async: req=%b full=%b addr=%h, want 0 0 0", mem_req_o, full_o,
               mem_addr_o);
    end
    @(negedge clk_i);
    rst_ni      = 1'b1;
    mem_ready_i = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      checks++;
      if (mem_req_o !== 1'b0) begin
        errors++;
        $display("FAIL rst_drain_noreq[%0d]: req=%b, want 0", c, mem_req_o);
      end
    end
    $display("test_reset_mid_drain done");
  endtask

  initial begin
    rst_ni      = 1'b0;
    wb_en_i     = 1'b0;
    wb_addr_i   = 32'h0;
    wb_data_i   = 32'h0;
    rd_addr_i   = 32'h0;
    mem_ready_i = 1'b0;
    test_reset();
    test_fill_drain();
    test_backpressure();
    test_fill_gaps();
    test_overflow();
    test_forward();
    test_reset_mid_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
